// File: rtl/pulse_conf_pkg.sv
// Shared definitions for the pulse configuration SPI transmitter:
// frame geometry, FSM state encoding and CLK_DIV/GAP legality limits.
package pulse_conf_pkg;

  localparam int unsigned CONF_W     = 64;
  localparam int unsigned HIGH_W     = 24;
  localparam int unsigned LOW_W      = 40;
  localparam int unsigned CONF_BYTES = 8;

  // Smallest SCLK half-period and inter-byte gap the receiver tolerates.
  localparam int unsigned CLK_DIV_MIN = 2;
  localparam int unsigned GAP_MIN     = 8;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT_HI,
    SHIFT_LO,
    BYTE_GAP,
    FINISH
  } state_t;

  function automatic bit params_legal(input int unsigned clk_div, input int unsigned gap);
    return (clk_div >= CLK_DIV_MIN) && (gap >= GAP_MIN);
  endfunction

endpackage

// File: rtl/pulse_conf_tx_tick.sv
// Loadable down-counter timing one FSM phase.
// Ports:
//   i_clk, i_reset  clock, synchronous active-low reset
//   load            start a new phase of load_val cycles
//   load_val        phase length in i_clk cycles (>= 1)
//   expire_c        high in the last cycle of the phase (combinational)
module pulse_conf_tx_tick #(
  parameter int unsigned W = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire_c
);

  logic [W-1:0] cnt;

  // Loading N makes the phase last N cycles: N-1 down to 0.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire_c = (cnt == '0);

endmodule

// File: rtl/pulse_conf_tx.sv
// SPI master (mode 0, MSB first) sending one 64-bit pulse configuration
// word {high_time[23:0], low_time[39:0]} as 8 bytes per i_start request.
// Ports:
//   i_clk, i_reset         clock, synchronous active-low reset
//   i_start                send request, sampled only in IDLE
//   i_high_time/low_time   word fields, latched at start
//   o_busy, o_done         transfer in progress / one-cycle completion
//   o_spi_clk/ncs/mosi     SPI pins
// Build option: PULSE_CONF_TX_CS_PER_BYTE_EN releases nCS during every
// inter-byte gap and re-runs chip-select setup before each byte.
module pulse_conf_tx
  import pulse_conf_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP     = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [HIGH_W-1:0] i_high_time,
  input  logic [LOW_W-1:0]  i_low_time,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_spi_clk,
  output logic              o_spi_ncs,
  output logic              o_spi_mosi
);

  localparam int unsigned PHASE_MAX = (GAP > CLK_DIV) ? GAP : CLK_DIV;
  localparam int unsigned CNT_W     = $clog2(PHASE_MAX + 1);
  localparam logic [2:0]  LAST_BYTE = 3'(CONF_BYTES - 1);

  if (!params_legal(CLK_DIV, GAP)) begin : g_bad_params
    $error("pulse_conf_tx: CLK_DIV must be >= %0d and GAP >= %0d", CLK_DIV_MIN, GAP_MIN);
  end

  state_t            state;
  logic [CONF_W-1:0] shreg;
  logic [2:0]        bit_cnt;
  logic [2:0]        byte_cnt;
  logic              load_c;
  logic [CNT_W-1:0]  load_val_c;
  logic              expire_c;

  pulse_conf_tx_tick #(.W(CNT_W)) u_tick (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .load     (load_c),
    .load_val (load_val_c),
    .expire_c (expire_c)
  );

  // Reload the phase timer on every state change; only BYTE_GAP uses GAP.
  always_comb begin
    load_c     = 1'b0;
    load_val_c = CNT_W'(CLK_DIV);
    case (state)
      IDLE:                                 load_c = i_start;
      CS_SETUP, SHIFT_HI, SHIFT_LO, BYTE_GAP: load_c = expire_c;
      default:                              load_c = 1'b0;
    endcase
    if (state == SHIFT_LO && bit_cnt == 3'd7 && byte_cnt != LAST_BYTE) begin
      load_val_c = CNT_W'(GAP);
    end
  end

  // FSM with outputs registered on the transition into each state.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_spi_clk  <= 1'b0;
      o_spi_ncs  <= 1'b1;
      o_spi_mosi <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            shreg      <= {i_high_time, i_low_time};
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            o_busy     <= 1'b1;
            o_spi_ncs  <= 1'b0;
            o_spi_mosi <= i_high_time[HIGH_W-1];
            state      <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (expire_c) begin
            o_spi_clk <= 1'b1;
            state     <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          // Falling SCLK edge: present the next bit immediately.
          if (expire_c) begin
            o_spi_clk  <= 1'b0;
            shreg      <= {shreg[CONF_W-2:0], 1'b0};
            o_spi_mosi <= shreg[CONF_W-2];
            state      <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (expire_c) begin
            if (bit_cnt != 3'd7) begin
              bit_cnt   <= bit_cnt + 3'd1;
              o_spi_clk <= 1'b1;
              state     <= SHIFT_HI;
            end else begin
              bit_cnt <= '0;
              if (byte_cnt != LAST_BYTE) begin
`ifdef PULSE_CONF_TX_CS_PER_BYTE_EN
                o_spi_ncs <= 1'b1;
`endif
                state <= BYTE_GAP;
              end else begin
                o_busy     <= 1'b0;
                o_done     <= 1'b1;
                o_spi_ncs  <= 1'b1;
                o_spi_mosi <= 1'b0;
                state      <= FINISH;
              end
            end
          end
        end
        BYTE_GAP: begin
          if (expire_c) begin
            byte_cnt <= byte_cnt + 3'd1;
`ifdef PULSE_CONF_TX_CS_PER_BYTE_EN
            o_spi_ncs <= 1'b0;
            state     <= CS_SETUP;
`else
            o_spi_clk <= 1'b1;
            state     <= SHIFT_HI;
`endif
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_conf_tx.sv
// Self-checking bench for pulse_conf_tx: an SPI monitor decodes each frame
// and the checks compare it with the word and timing the frame rules imply.
module tb_pulse_conf_tx;

  localparam int unsigned CD = 4;
  localparam int unsigned GP = 16;
`ifdef PULSE_CONF_TX_CS_PER_BYTE_EN
  localparam int unsigned FRAME   = 8 * 17 * CD + 7 * GP;
  localparam int unsigned WIN_N   = 8;
  localparam int unsigned WIN_LEN = 17 * CD;
  localparam int unsigned NCS_LOW = 8 * 17 * CD;
`else
  localparam int unsigned FRAME   = CD + 128 * CD + 7 * GP;
  localparam int unsigned WIN_N   = 1;
  localparam int unsigned WIN_LEN = FRAME;
  localparam int unsigned NCS_LOW = FRAME;
`endif
  localparam int unsigned EXP_DONE = FRAME + 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] high;
  logic [39:0] low;
  logic        busy, done, sclk, ncs, mosi;

  pulse_conf_tx #(.CLK_DIV(CD), .GAP(GP)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_start     (start),
    .i_high_time (high),
    .i_low_time  (low),
    .o_busy      (busy),
    .o_done      (done),
    .o_spi_clk   (sclk),
    .o_spi_ncs   (ncs),
    .o_spi_mosi  (mosi)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  // Monitor state
  int          rises, first_rise, ncs_low, busy_cyc, windows, cur_win;
  int          win_bad, mosi_bad, done_cnt, done_at;
  logic [63:0] dec;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;
  logic        prev_ncs  = 1'b1;

  always @(posedge clk) cyc++;

  // SPI monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (sclk && !prev_sclk) begin
      if (rises == 0) first_rise = cyc - t0;
      rises++;
      dec = {dec[62:0], mosi};
    end
    if (sclk && prev_sclk && mosi !== prev_mosi) mosi_bad++;
    if (!ncs && prev_ncs) begin
      windows++;
      cur_win = 0;
    end
    if (!ncs) begin
      ncs_low++;
      cur_win++;
    end
    if (ncs && !prev_ncs && cur_win != int'(WIN_LEN)) win_bad++;
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      done_at = cyc - t0;
    end
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_ncs  = ncs;
  end

  task automatic clear_mon();
    rises = 0; first_rise = -1; ncs_low = 0; busy_cyc = 0; windows = 0;
    cur_win = 0; win_bad = 0; mosi_bad = 0; done_cnt = 0; done_at = -1;
    dec = '0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string what, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s observed %0h expected %0h", tag, what, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {busy, done, sclk, ncs, mosi};
  endfunction

  // Request one frame; inputs are scrambled right after the start cycle.
  task automatic launch(input logic [23:0] h, input logic [39:0] l);
    step();
    clear_mon();
    high  = h;
    low   = l;
    start = 1'b1;
    t0    = cyc;
    step();
    start = 1'b0;
    high  = 24'($urandom());
    low   = {8'($urandom()), $urandom()};
  endtask

  // Wait for o_done and compare the decoded frame with the expected one.
  task automatic finish_check(input string tag, input logic [23:0] h, input logic [39:0] l);
    for (int k = 0; k < 4000 && done_cnt == 0; k++) step();
    chk(tag, "done_count", 64'(done_cnt), 64'd1);
    chk(tag, "done_cycle", 64'(done_at), 64'(EXP_DONE));
    chk(tag, "word", dec, {h, l});
    chk(tag, "sclk_rises", 64'(rises), 64'd64);
    chk(tag, "first_rise", 64'(first_rise), 64'(1 + CD));
    chk(tag, "ncs_low", 64'(ncs_low), 64'(NCS_LOW));
    chk(tag, "busy_cycles", 64'(busy_cyc), 64'(FRAME));
    chk(tag, "ncs_windows", 64'(windows), 64'(WIN_N));
    chk(tag, "window_len", 64'(win_bad), 64'd0);
    chk(tag, "mosi_stable", 64'(mosi_bad), 64'd0);
    chk(tag, "done_outs", 64'(outs()), 64'(5'b01010));
  endtask

  logic [23:0] h;
  logic [39:0] l;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    high  = '0;
    low   = '0;
    clear_mon();
    repeat (5) step();
    chk("reset", "held_outs", 64'(outs()), 64'(5'b00010));
    rst_n = 1'b1;
    repeat (3) step();
    chk("reset", "release_outs", 64'(outs()), 64'(5'b00010));
    chk("reset", "no_sclk", 64'(rises), 64'd0);

    // Reference word from the receiver bring-up.
    launch(24'h000032, 40'h00000000C8);
    finish_check("fixed", 24'h000032, 40'h00000000C8);

    // Random words, each started in the cycle after the previous o_done.
    for (int i = 0; i < 3; i++) begin
      h = 24'($urandom());
      l = {8'($urandom()), $urandom()};
      launch(h, l);
      finish_check("random", h, l);
    end

    // Start held and inputs changed mid-frame: ignored.
    h = 24'($urandom());
    l = {8'($urandom()), $urandom()};
    launch(h, l);
    repeat (150) step();
    start = 1'b1;
    high  = ~h;
    low   = ~l;
    repeat (200) step();
    start = 1'b0;
    finish_check("midstart", h, l);
    repeat (20) step();
    chk("midstart", "single_done", 64'(done_cnt), 64'd1);
    chk("midstart", "idle_after", 64'(outs()), 64'(5'b00010));

    // Reset at cycle 300 aborts the frame silently.
    h = 24'($urandom());
    l = {8'($urandom()), $urandom()};
    launch(h, l);
    for (int k = 0; k < 1000 && (cyc - t0) < 300; k++) step();
    rst_n = 1'b0;
    step();
    chk("abort", "cycle", 64'(cyc - t0), 64'd301);
    chk("abort", "idle_outs", 64'(outs()), 64'(5'b00010));
    rst_n = 1'b1;
    repeat (800) step();
    chk("abort", "no_done", 64'(done_cnt), 64'd0);
    chk("abort", "stays_idle", 64'(outs()), 64'(5'b00010));

    h = 24'($urandom());
    l = {8'($urandom()), $urandom()};
    launch(h, l);
    finish_check("after_reset", h, l);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
